// File: rtl/vm_pkg.sv
// ============================================================================
// Module   : vm_pkg
// Brief    : Shared types and helpers for the multi-candidate voting machine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vm_pkg;

    localparam int c_MAX_BTNS = 16;
    localparam int c_SEL_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        CAST     = 2'd2,
        WAIT_REL = 2'd3
    } vm_state_t;

    // True when exactly one bit is set (clears the lowest set bit and tests for zero).
    function automatic logic is_single(input logic [c_MAX_BTNS-1:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

    function automatic logic [c_SEL_W-1:0] onehot_idx(input logic [c_MAX_BTNS-1:0] v);
        logic [c_SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_BTNS; i++) begin
            if (v[i]) idx = c_SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vm_hold_timer.sv
// ============================================================================
// Module   : vm_hold_timer
// Brief    : Loadable up/down counter with clear, enable and a done compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vm_hold_timer #(
    parameter int W        = 8,
    parameter bit UP       = 1'b1,
    parameter int DONE_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] r_count;

    // Down mode stops at zero so an idle timer stays expired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (enable) begin
            if (UP) begin
                r_count <= r_count + W'(1);
            end else if (r_count != '0) begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign count = r_count;
    assign done  = (r_count == W'(DONE_VAL));

endmodule

`default_nettype wire

// File: rtl/vm_multi.sv
// ============================================================================
// Module   : vm_multi
// Brief    : N-candidate voting machine with hold-to-cast, saturating tallies
//            and a vote LED. Optional macro VM_ARM_EN enables one-vote-per-arm.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vm_multi
    import vm_pkg::*;
#(
    parameter int N_CAND      = 2,
    parameter int CTR_W       = 3,
    parameter int HOLD_CYCLES = 3000000,
    parameter int LED_CYCLES  = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CAND-1:0]             vote_btn,
    input  logic                          null_btn,
    input  logic                          arm,
    output logic                          led,
    output logic [(N_CAND+1)*CTR_W-1:0]   ctr,
    output logic                          sat,
    output logic                          armed
);

    localparam int               c_NB        = N_CAND + 1;
    localparam int               c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam int               c_LED_W     = $clog2(LED_CYCLES + 1);
    localparam logic [CTR_W-1:0] c_TALLY_MAX = {CTR_W{1'b1}};

    vm_state_t              r_state, w_state_next;
    logic [c_SEL_W-1:0]     r_sel;
    logic [c_NB-1:0]        w_btn;
    logic [c_MAX_BTNS-1:0]  w_btn_ext;
    logic                   w_single, w_match, w_can_vote;
    logic                   w_sel_load, w_hold_load, w_hold_en, w_hold_clear, w_cast;
    logic                   w_hold_done;
    logic [c_HOLD_W-1:0]    w_unused_hold_cnt;
    logic [c_LED_W-1:0]     w_led_cnt;
    logic                   w_led_done;
    logic [c_NB-1:0]        w_at_max;
    logic                   r_led, r_sat;

    assign w_btn     = {null_btn, vote_btn};
    assign w_btn_ext = c_MAX_BTNS'(w_btn);
    assign w_single  = is_single(w_btn_ext);
    assign w_match   = (w_btn == (c_NB'(1) << r_sel));

`ifdef VM_ARM_EN
    logic r_armed;

    // A coincident arm wins over the clear from CAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_armed <= 1'b0;
        else if (arm)    r_armed <= 1'b1;
        else if (w_cast) r_armed <= 1'b0;
    end

    assign armed      = r_armed;
    assign w_can_vote = r_armed;
`else
    logic w_unused_arm;
    assign w_unused_arm = arm;
    assign armed        = 1'b1;
    assign w_can_vote   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_sel_load) r_sel <= onehot_idx(w_btn_ext);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_load   = 1'b0;
        w_hold_load  = 1'b0;
        w_hold_en    = 1'b0;
        w_cast       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_can_vote && w_single) begin
                    w_sel_load = 1'b1;
                    if (HOLD_CYCLES == 1) begin
                        w_state_next = CAST;
                    end else begin
                        w_hold_load  = 1'b1;
                        w_state_next = HOLD;
                    end
                end else if (w_btn != '0 && !w_single) begin
                    w_state_next = WAIT_REL;
                end
            end
            HOLD: begin
                if (w_match) begin
                    w_hold_en = 1'b1;
                    if (w_hold_done) w_state_next = CAST;
                end else if (w_btn == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = WAIT_REL;
                end
            end
            CAST: begin
                w_cast       = 1'b1;
                w_state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (w_btn == '0) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_hold_clear = (r_state != HOLD) && !w_hold_load;

    // done fires when the count is one short, so this sample completes the hold.
    vm_hold_timer #(
        .W        (c_HOLD_W),
        .UP       (1'b1),
        .DONE_VAL (HOLD_CYCLES - 1)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_hold_clear),
        .load     (w_hold_load),
        .load_val (c_HOLD_W'(1)),
        .enable   (w_hold_en),
        .count    (w_unused_hold_cnt),
        .done     (w_hold_done)
    );

    vm_hold_timer #(
        .W        (c_LED_W),
        .UP       (1'b0),
        .DONE_VAL (1)
    ) u_led_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .load     (w_cast),
        .load_val (c_LED_W'(LED_CYCLES)),
        .enable   (1'b1),
        .count    (w_led_cnt),
        .done     (w_led_done)
    );

    // led tracks the timer's next value so it is a true register yet matches count != 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led <= 1'b0;
            r_sat <= 1'b0;
        end else begin
            r_led <= w_cast || ((w_led_cnt != '0) && !w_led_done);
            r_sat <= |w_at_max;
        end
    end

    assign led = r_led;
    assign sat = r_sat;

    for (genvar i = 0; i < c_NB; i++) begin : g_tally
        logic [CTR_W-1:0] r_tally;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_tally <= '0;
            end else if (w_cast && (r_sel == c_SEL_W'(i)) && !w_at_max[i]) begin
                r_tally <= r_tally + CTR_W'(1);
            end
        end

        assign w_at_max[i]              = (r_tally == c_TALLY_MAX);
        assign ctr[i*CTR_W +: CTR_W]    = r_tally;
    end

endmodule

`default_nettype wire

// File: tb/tb_vm_multi.sv
// ============================================================================
// Module   : tb_vm_multi
// Brief    : Directed self-checking bench for vm_multi (HOLD=4, LED=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vm_multi;

    logic       clk;
    logic       rst;
    logic [1:0] vote_btn;
    logic       null_btn;
    logic       arm;
    logic       led;
    logic [8:0] ctr;
    logic       sat;
    logic       armed;

    int n_vec;
    int n_err;

    vm_multi #(
        .N_CAND      (2),
        .CTR_W       (3),
        .HOLD_CYCLES (4),
        .LED_CYCLES  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vote_btn (vote_btn),
        .null_btn (null_btn),
        .arm      (arm),
        .led      (led),
        .ctr      (ctr),
        .sat      (sat),
        .armed    (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold a button pattern for n sampled edges, release, and settle back to IDLE.
    task automatic press(input logic [1:0] v, input logic nb, input int n);
        vote_btn = v;
        null_btn = nb;
        step(n);
        vote_btn = 2'b00;
        null_btn = 1'b0;
        step(2);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        vote_btn = 2'b00;
        null_btn = 1'b0;
        arm      = 1'b0;
        step(2);
        chk("reset_ctr", 32'(ctr), 32'h0);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_sat", 32'(sat), 32'h0);
        chk("reset_armed", 32'(armed), 32'h1);
        rst = 1'b1;
        step(1);

        // Cast to candidate 0 with latency and LED width checks.
        vote_btn = 2'b01;
        step(3);
        chk("mid_hold_ctr", 32'(ctr), 32'h0);
        step(1);
        chk("pre_cast_ctr", 32'(ctr), 32'h0);
        vote_btn = 2'b00;
        step(1);
        chk("cast_c0_ctr", 32'(ctr), 32'h001);
        chk("led_cycle1", 32'(led), 32'h1);
        step(1);
        chk("led_cycle2", 32'(led), 32'h1);
        step(1);
        chk("led_cycle3", 32'(led), 32'h1);
        step(1);
        chk("led_off", 32'(led), 32'h0);

        press(2'b01, 1'b0, 3);
        chk("short_hold_ctr", 32'(ctr), 32'h001);

        press(2'b10, 1'b0, 20);
        chk("long_hold_ctr", 32'(ctr), 32'h009);
        press(2'b10, 1'b0, 4);
        chk("second_c1_ctr", 32'(ctr), 32'h011);

        press(2'b11, 1'b0, 10);
        chk("multi_c0c1_ctr", 32'(ctr), 32'h011);
        press(2'b01, 1'b1, 10);
        chk("multi_null_c0_ctr", 32'(ctr), 32'h011);
        press(2'b01, 1'b0, 4);
        chk("after_multi_ctr", 32'(ctr), 32'h012);

        // Switch buttons mid-hold: rejected until full release.
        vote_btn = 2'b01;
        step(2);
        vote_btn = 2'b10;
        step(10);
        chk("switch_held_ctr", 32'(ctr), 32'h012);
        vote_btn = 2'b00;
        step(2);
        chk("switch_rel_ctr", 32'(ctr), 32'h012);
        press(2'b10, 1'b0, 4);
        chk("after_switch_ctr", 32'(ctr), 32'h01A);

        for (int i = 0; i < 6; i++) press(2'b00, 1'b1, 4);
        chk("null6_ctr", 32'(ctr), 32'h19A);
        chk("null6_sat", 32'(sat), 32'h0);
        for (int i = 0; i < 3; i++) press(2'b00, 1'b1, 4);
        chk("null9_ctr", 32'(ctr), 32'h1DA);
        chk("null9_sat", 32'(sat), 32'h1);
        press(2'b01, 1'b0, 4);
        chk("sat_other_ctr", 32'(ctr), 32'h1DB);
        chk("sat_other_sat", 32'(sat), 32'h1);

        // Async reset mid-HOLD while the LED pulse is still running.
        vote_btn = 2'b10;
        step(1);
        chk("pre_rst_led", 32'(led), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ctr", 32'(ctr), 32'h0);
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_sat", 32'(sat), 32'h0);
        vote_btn = 2'b00;
        step(2);
        rst = 1'b1;
        step(1);
        press(2'b01, 1'b0, 4);
        chk("post_rst_ctr", 32'(ctr), 32'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vm_multi.md
Name: vm_multi

Overview:
- Parametrised successor to the three-way voting machine. Supports N_CAND candidate buttons plus a null/abstain button.
- A vote is cast only after exactly one button is held stable for HOLD_CYCLES clocks. The block then waits for full release before accepting the next vote.
- Per-choice tallies saturate rather than wrap. A status LED pulses for a fixed time on each accepted vote.
- Sits between upstream button synchronisers and the display/readout logic.

Parameters:
- N_CAND, 2, number of candidate buttons (1..15).
- CTR_W, 3, width of each tally counter.
- HOLD_CYCLES, 3000000, consecutive clocks a single button must be held to cast (>=1).
- LED_CYCLES, 1000000, clocks the led output stays high after a cast (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- vote_btn  in  N_CAND  candidate buttons, bit i = candidate i; synchronous to clk (synchronisers are upstream).
- null_btn  in  1  null/abstain button, synchronous to clk.
- arm  in  1  ballot-officer arm pulse; used only with VM_ARM_EN.
- led  out  1  vote-accepted indicator.
- ctr  out  (N_CAND+1)*CTR_W  packed tallies:
  - candidate i at [i*CTR_W +: CTR_W];
  - null at [N_CAND*CTR_W +: CTR_W].
- sat  out  1  high while any tally equals 2^CTR_W-1.
- armed  out  1  ready to accept a vote.

Behaviour:
- Reset (rst=0, async) clears all of the following:
  - FSM -> IDLE;
  - all ctr fields -> 0, sat=0;
  - led=0, led timer=0, hold counter=0;
  - armed=0 with VM_ARM_EN, 1 without.
- All outputs are registered.
- Button vector B = {null_btn, vote_btn}, width N_CAND+1. "Single" means exactly one bit of B is set; its index is sel.
- FSM states:
  - IDLE:
    - if armed and B single: latch sel, hold_cnt=1, go to HOLD. If HOLD_CYCLES==1, go directly to CAST.
    - if B is non-zero but not single: go to WAIT_REL (multi-press rejected, no vote).
  - HOLD:
    - if B == one-hot(sel): hold_cnt++. When hold_cnt reaches HOLD_CYCLES, go to CAST.
    - if B == 0 (early release): return to IDLE, no vote.
    - if any other bit is set: go to WAIT_REL, no vote.
  - CAST (exactly one cycle):
    - tally[sel]++ unless already at max (saturates, no wrap);
    - load led timer with LED_CYCLES;
    - clear armed (VM_ARM_EN only);
    - go to WAIT_REL.
  - WAIT_REL: stay until B == 0, then go to IDLE. Holding a button past the cast never casts a second vote.
- Latency: the tally and led update on the clock edge after the HOLD_CYCLES-th consecutive sampled edge. So if the button rises before edge k, the tally is visible after edge k+HOLD_CYCLES.
- led:
  - high while the led timer is non-zero; the timer decrements every cycle independent of FSM state;
  - a new cast during an active pulse reloads the timer.
- sat is combinational OR of per-field max compares, registered one cycle late. A saturated tally does not block casting to other choices.
- Reset asserted mid-HOLD or mid-led-pulse aborts immediately; no partial vote is recorded.

Optional Feature:
- VM_ARM_EN:
  - Defined: armed is set by an arm=1 sample in any state, and cleared in CAST. IDLE ignores buttons while armed=0, so one arm gives one vote. arm coinciding with CAST leaves armed=1 (set wins).
  - Undefined: armed is tied to 1, the arm input is ignored, and voting is unrestricted.

Decomposition:
- Shared package vm_pkg:
  - FSM state enum (IDLE, HOLD, CAST, WAIT_REL);
  - helper function for the one-hot/single check;
  - localparam for tally max.
- One natural sub-module: vm_hold_timer, the parametrised hold counter. It exposes clear/enable/done and is reusable for the led timer with a load input.
- Tally registers stay in the top level as a generate loop.

Test Plan:
- Use N_CAND=2, CTR_W=3, HOLD_CYCLES=4, LED_CYCLES=3, VM_ARM_EN undefined unless noted.
- Early release: vote_btn=01 held 4 edges, then released -> ctr[2:0]=1, led high for exactly 3 cycles. Same button held only 3 edges -> no change.
- Long hold: vote_btn=10 held 20 edges -> ctr[5:3]=1, not 2. Release, then hold again 4 edges -> ctr[5:3]=2.
- Multi-press: vote_btn=11, or null_btn with vote_btn=01, held 10 edges -> all tallies unchanged. A single press after full release is then accepted.
- Button switch mid-hold: hold 01 for 2 edges, switch to 10 -> WAIT_REL, no vote until all buttons are released.
- Saturation: null_btn cast 9 times -> null field stays 7, sat=1. A further candidate vote still increments ctr[2:0].
- Arm and reset:
  - with VM_ARM_EN: press before arm -> ignored; arm pulse then cast -> tally 1 and armed=0; second cast without arm -> ignored.
  - rst low mid-HOLD -> all zero, async.
